// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the arbitrated UART
//                transmitter (FSM state encoding, data width, frame lengths,
//                baud divisor helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  // Frame length in bit times: start + 8 data + stop, optionally + parity.
  localparam int UART_FRAME_BITS_8N1  = 10;
  localparam int UART_FRAME_BITS_8E1  = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int uart_divisor(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. Counts 0..DIVISOR-1 and wraps; tick is
//                high on the last cycle of each bit period. A synchronous
//                clear restarts the period at count 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count;

  // Period counter; clear aligns bit boundaries to the start of a frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Tick marks the final cycle of the current bit.
  always_comb begin
    tick = (count == CNT_LAST);
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART TX line among NUM_REQ
//                byte requesters. Winner is accepted with a one-cycle
//                valid/ready handshake in IDLE, then serialized LSB first.
//                Build option UART_TX_ARB_PARITY_EN: when defined, an even
//                parity bit is sent after the data (8E1); otherwise 8N1.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int CLK_FREQ  = 50000000,
  parameter  int BAUD_RATE = 115200,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [ID_W-1:0]      GRANT_ID,
  output logic                 BUSY,
  output logic                 STX
);

  localparam int DIVISOR = uart_divisor(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_arbiter: DIVISOR must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
  endgenerate

  uart_state_t     state;
  uart_state_t     next_state;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_next;
  logic [7:0]      data_q;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;
  logic            any_valid;
  logic [7:0]      win_data;
  logic            accept;
  logic            tick;
  logic            stx_d;
  logic            busy_d;

  uart_baud_tick #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .clk  (CLOCK),
    .rst  (RESET),
    .clear(accept),
    .tick (tick)
  );

  // Round-robin pick: first valid requester searching upward from last+1.
  // Both loops run over constants so every select is static.
  always_comb begin
    winner    = last;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((last == ID_W'((i - k + NUM_REQ) % NUM_REQ)) && !any_valid && REQ_VALID[i]) begin
          any_valid = 1'b1;
          winner    = ID_W'(i);
        end
      end
    end
  end

  // Byte of the current winner and the one-hot acceptance pulse.
  always_comb begin
    accept   = (state == ST_IDLE) && any_valid;
    win_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_data = REQ_DATA[8*i +: 8];
      end
      REQ_READY[i] = accept && !RESET && (winner == ID_W'(i));
    end
  end

  // State register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      bit_idx <= 3'd0;
    end else begin
      state   <= next_state;
      bit_idx <= bit_idx_next;
    end
  end

  // Next-state logic; each non-idle state lasts whole bit periods.
  always_comb begin
    next_state   = state;
    bit_idx_next = bit_idx;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          next_state   = ST_START;
          bit_idx_next = 3'd0;
        end
      end
      ST_START: begin
        if (tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_ARB_PARITY_EN
            next_state = ST_PARITY;
`else
            next_state = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      ST_PARITY: begin
        if (tick) next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Line level and busy flag for the coming cycle, from the next state.
  always_comb begin
    busy_d = (next_state != ST_IDLE);
    stx_d  = 1'b1;
    case (next_state)
      ST_START: stx_d = 1'b0;
      ST_DATA:  stx_d = data_q[bit_idx_next];
`ifdef UART_TX_ARB_PARITY_EN
      ST_PARITY: stx_d = ^data_q;
`endif
      default:  stx_d = 1'b1;
    endcase
  end

  // Registered outputs and the handshake datapath.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      STX      <= 1'b1;
      BUSY     <= 1'b0;
      GRANT_ID <= '0;
      last     <= ID_W'(NUM_REQ - 1);
      data_q   <= 8'h00;
    end else begin
      STX  <= stx_d;
      BUSY <= busy_d;
      if (accept) begin
        data_q   <= win_data;
        last     <= winner;
        GRANT_ID <= winner;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Accepted bytes are
//                queued as expectations; a line decoder rebuilds frames from
//                STX and each test compares them in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CLK_FREQ  = 1152000;
  localparam int BAUD_RATE = 115200;
  localparam int DIV       = 10;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        stx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  int         hs_idx[$];
  int         hs_cyc[$];

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .REQ_VALID(req_valid),
    .REQ_DATA (req_data),
    .REQ_READY(req_ready),
    .GRANT_ID (grant_id),
    .BUSY     (busy),
    .STX      (stx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit, drops frames interrupted by reset.
  logic mon_prev = 1'b1;
  always begin : line_decoder
    logic [7:0] b;
    logic       perr;
    logic       serr;
    logic       ab;
    @(negedge clk);
    if (!rst && mon_prev === 1'b1 && stx === 1'b0) begin
      b = 8'h00; perr = 1'b0; serr = 1'b0; ab = 1'b0;
      for (int c = 0; c < DIV/2 - 1 && !ab; c++) begin
        @(negedge clk); if (rst) ab = 1'b1;
      end
      if (stx !== 1'b0) serr = 1'b1;
      for (int j = 0; j < FRAME_BITS - 1 && !ab; j++) begin
        for (int c = 0; c < DIV && !ab; c++) begin
          @(negedge clk); if (rst) ab = 1'b1;
        end
        if (!ab) begin
          if (j < 8) b = {stx, b[7:1]};
          else if (j == FRAME_BITS - 2) begin if (stx !== 1'b1) serr = 1'b1; end
          else begin if (stx !== ^b) perr = 1'b1; end
        end
      end
      if (!ab) begin
        rx_q.push_back({perr, serr, b});
        $display("tty: 0x%02h", b);
      end
    end
    mon_prev = stx;
  end

  // Expected line level for cycle k of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int bi;
    bi = k / DIV;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return d[bi-1];
    if (FRAME_BITS == 11 && bi == 9) return ^d;
    return 1'b1;
  endfunction

  // One clock of requester behaviour: record acceptances, drop accepted
  // bytes unless the requester keeps its valid held.
  task automatic step(input logic [3:0] hold);
    logic [3:0] r;
    @(negedge clk);
    r = req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[i]) begin
        hs_idx.push_back(i);
        hs_cyc.push_back(cyc);
        exp_q.push_back({2'b00, req_data[8*i +: 8]});
      end
    end
    @(posedge clk); #1;
    req_valid = req_valid & ~(r & ~hold);
  endtask

  task automatic do_reset();
    req_valid = 4'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); rx_q.delete(); hs_idx.delete(); hs_cyc.delete();
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (stx !== 1'b1) begin errors++; $display("FAIL reset_stx got=%b exp=1", stx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    req_valid = 4'h0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [9:0] e, a;
    int stx_bad, busy_bad, busy_hi, rdy_extra;
    do_reset();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    for (int n = 0; n < 20 && hs_idx.size() == 0; n++) step(4'b0000);
    checks++;
    if (hs_idx.size() != 1 || hs_idx[0] != 0) begin
      errors++; $display("FAIL single_ready got_count=%0d exp=1 on req0", hs_idx.size());
    end
    stx_bad = 0; busy_bad = 0; busy_hi = 0; rdy_extra = 0;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
      end
      if (stx !== ((k < FRAME_CYC) ? frame_bit(8'hA5, k) : 1'b1)) stx_bad++;
      if (busy !== (k < FRAME_CYC)) busy_bad++;
      if (busy === 1'b1) busy_hi++;
      if (req_ready !== 4'h0) rdy_extra++;
    end
    checks++; if (stx_bad != 0) begin errors++; $display("FAIL single_stx_pattern bad_cycles got=%0d exp=0", stx_bad); end
    checks++; if (busy_hi != FRAME_CYC || busy_bad != 0) begin
      errors++; $display("FAIL single_busy got=%0d cycles (misplaced %0d) exp=%0d", busy_hi, busy_bad, FRAME_CYC);
    end
    checks++; if (rdy_extra != 0) begin errors++; $display("FAIL single_ready_width extra_cycles got=%0d exp=0", rdy_extra); end
    for (int w = 0; w < 50 && rx_q.size() < exp_q.size(); w++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL single_frame got=none exp=%h", e); end
      else begin a = rx_q.pop_front(); if (a !== e) begin errors++; $display("FAIL single_frame got=%h exp=%h", a, e); end end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL single_extra got=%0d exp=0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_round_robin();
    logic [9:0] e, a;
    do_reset();
    req_data = 32'h33323130;
    req_valid = 4'hF;
    for (int c = 0; c < 4 * (FRAME_CYC + 1) + 20 && hs_idx.size() < 4; c++) step(4'b0000);
    repeat (FRAME_CYC + 10) @(negedge clk);
    checks++;
    if (hs_idx.size() != 4) begin
      errors++; $display("FAIL rr_count got=%0d exp=4", hs_idx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (hs_idx[i] != i) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, hs_idx[i], i); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (hs_cyc[i] - hs_cyc[i-1] != FRAME_CYC + 1) begin
          errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i, hs_cyc[i] - hs_cyc[i-1], FRAME_CYC + 1);
        end
      end
    end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rr_last_grant got=%0d exp=3", grant_id); end
    for (int w = 0; w < 50 && rx_q.size() < exp_q.size(); w++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL rr_frame got=none exp=%h", e); end
      else begin a = rx_q.pop_front(); if (a !== e) begin errors++; $display("FAIL rr_frame got=%h exp=%h", a, e); end end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rr_extra got=%0d exp=0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_back_to_back_alternate();
    logic [9:0] e, a;
    int exp_seq[4];
    exp_seq = '{1, 2, 1, 2};
    do_reset();
    req_data[15:8]  = 8'h41;
    req_data[23:16] = 8'h42;
    req_valid = 4'b0010;
    for (int n = 0; n < 20 && hs_idx.size() == 0; n++) step(4'b0010);
    repeat (30) step(4'b0010);
    req_valid[2] = 1'b1;
    for (int c = 0; c < 5 * (FRAME_CYC + 1) && hs_idx.size() < 4; c++) step(4'b0110);
    req_valid = 4'h0;
    repeat (FRAME_CYC + 10) @(negedge clk);
    checks++;
    if (hs_idx.size() != 4) begin
      errors++; $display("FAIL alt_count got=%0d exp=4", hs_idx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (hs_idx[i] != exp_seq[i]) begin errors++; $display("FAIL alt_order[%0d] got=%0d exp=%0d", i, hs_idx[i], exp_seq[i]); end
      end
    end
    for (int w = 0; w < 50 && rx_q.size() < exp_q.size(); w++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL alt_frame got=none exp=%h", e); end
      else begin a = rx_q.pop_front(); if (a !== e) begin errors++; $display("FAIL alt_frame got=%h exp=%h", a, e); end end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL alt_extra got=%0d exp=0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] e, a;
    do_reset();
    req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    for (int n = 0; n < 20 && hs_idx.size() == 0; n++) step(4'b0000);
    // Now just past the edge where the start bit began; data bit 4 spans
    // cycles 50..59 of the frame.
    repeat (54) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin
      errors++; $display("FAIL mid_pre_reset got busy=%b grant=%0d exp busy=1 grant=2", busy, grant_id);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (stx !== 1'b1) begin errors++; $display("FAIL mid_reset_stx got=%b exp=1", stx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_reset_grant got=%0d exp=0", grant_id); end
    rst = 1'b0;
    exp_q.delete(); hs_idx.delete(); hs_cyc.delete();
    req_data[7:0]   = 8'h10;
    req_data[31:24] = 8'h13;
    req_valid = 4'b1001;
    for (int c = 0; c < 3 * (FRAME_CYC + 1) && hs_idx.size() < 2; c++) step(4'b0000);
    repeat (FRAME_CYC + 10) @(negedge clk);
    checks++;
    if (hs_idx.size() != 2 || hs_idx[0] != 0 || hs_idx[1] != 3) begin
      errors++; $display("FAIL mid_after_order got_count=%0d first=%0d exp first=0 then 3", hs_idx.size(),
                         (hs_idx.size() > 0) ? hs_idx[0] : -1);
    end
    for (int w = 0; w < 50 && rx_q.size() < exp_q.size(); w++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL mid_frame got=none exp=%h", e); end
      else begin a = rx_q.pop_front(); if (a !== e) begin errors++; $display("FAIL mid_frame got=%h exp=%h", a, e); end end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL mid_extra got=%0d exp=0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_drop_while_busy();
    logic [9:0] e, a;
    do_reset();
    req_data[7:0]   = 8'h77;
    req_data[31:24] = 8'hEE;
    req_valid = 4'b0001;
    for (int n = 0; n < 20 && hs_idx.size() == 0; n++) step(4'b0000);
    repeat (20) step(4'b0000);
    req_valid[3] = 1'b1;
    step(4'b0000);
    req_valid[3] = 1'b0;
    repeat (FRAME_CYC + 30) step(4'b0000);
    checks++;
    if (hs_idx.size() != 1 || hs_idx[0] != 0) begin
      errors++; $display("FAIL drop_handshakes got=%0d exp=1 (req0 only)", hs_idx.size());
    end
    for (int w = 0; w < 50 && rx_q.size() < exp_q.size(); w++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL drop_frame got=none exp=%h", e); end
      else begin a = rx_q.pop_front(); if (a !== e) begin errors++; $display("FAIL drop_frame got=%h exp=%h", a, e); end end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL drop_extra got=%0d exp=0", rx_q.size()); rx_q.delete(); end
  endtask

`ifdef UART_TX_ARB_PARITY_EN
  task automatic test_parity();
    int busy_hi;
    logic par;
    do_reset();
    req_data[7:0] = 8'h07;
    req_valid = 4'b0001;
    for (int n = 0; n < 20 && hs_idx.size() == 0; n++) step(4'b0000);
    busy_hi = 0; par = 1'b0;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_hi++;
      if (k == 95) par = stx;
    end
    checks++; if (par !== 1'b1) begin errors++; $display("FAIL parity_bit got=%b exp=1", par); end
    checks++; if (busy_hi != 110) begin errors++; $display("FAIL parity_busy got=%0d exp=110", busy_hi); end
  endtask
`endif

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_alternate();
    test_reset_mid_frame();
    test_drop_while_busy();
`ifdef UART_TX_ARB_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
